demux_onehot_stream: RTL

- Reverse direction of the one-hot sample multiplexer: takes one input sample stream and steers each sample to one of four output channels using a one-hot select.
- Each channel has a one-deep holding register with a valid/ready handshake, so downstream DSP stages can stall independently.
- Two routing modes: external one-hot SEL, or an internal rotating one-hot pointer for round-robin distribution.
- Sits between the sample source and the per-channel DSP/controller paths.

---
 rtl/demux_onehot_stream_pkg.sv | 18 +
 rtl/demux_onehot_stream_chan_reg.sv | 27 ++
 rtl/demux_onehot_stream.sv | 111 +++++++++++
 3 files changed

// File: rtl/demux_onehot_stream_pkg.sv
// Shared one-hot channel codes and helpers for the four-way sample demultiplexer.
package demux_onehot_stream_pkg;

    localparam logic [3:0] ONEHOT_CH1 = 4'b0001;
    localparam logic [3:0] ONEHOT_CH2 = 4'b0010;
    localparam logic [3:0] ONEHOT_CH3 = 4'b0100;
    localparam logic [3:0] ONEHOT_CH4 = 4'b1000;

    typedef enum logic {
        ROUTE_SEL = 1'b0,
        ROUTE_PTR = 1'b1
    } route_mode_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/demux_onehot_stream_chan_reg.sv
// One-deep output holding register with valid; a load always wins over a drain.
module demux_chan_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            data_out <= data_in;
            valid    <= 1'b1;
        end else if (valid && out_ready) begin
            // data is kept after a drain; only the valid flag drops
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_onehot_stream.sv
// Steers one input sample stream to four held output channels by one-hot SEL or a rotating pointer.
module demux_onehot_stream
    import demux_onehot_stream_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 16,
    parameter logic [3:0]  PTR_RESET   = ONEHOT_CH1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [INPUT_WIDTH-1:0] IN,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [3:0]             SEL,
    input  logic                   MODE,
    output logic [3:0]             PTR,
    output logic [INPUT_WIDTH-1:0] OUT1,
    output logic [INPUT_WIDTH-1:0] OUT2,
    output logic [INPUT_WIDTH-1:0] OUT3,
    output logic [INPUT_WIDTH-1:0] OUT4,
    output logic [3:0]             OUT_VALID,
    input  logic [3:0]             OUT_READY,
    output logic                   ERR,
    input  logic                   ERR_CLR
);

    route_mode_e route_mode;
    logic [3:0]  tgt;
    logic        tgt_ok;
    logic [3:0]  chan_free;
    logic        accept;
    logic        drop;
    logic [3:0]  load;

    assign route_mode = route_mode_e'(MODE);
    assign tgt        = (route_mode == ROUTE_PTR) ? PTR : SEL;
    assign tgt_ok     = is_onehot4(tgt);
    assign chan_free  = ~OUT_VALID | OUT_READY;

    // Invalid targets are always ready so a bad select never stalls the source.
    always_comb begin
        IN_READY = 1'b1;
        case (tgt)
            ONEHOT_CH1: IN_READY = chan_free[0];
            ONEHOT_CH2: IN_READY = chan_free[1];
            ONEHOT_CH3: IN_READY = chan_free[2];
            ONEHOT_CH4: IN_READY = chan_free[3];
            default:    IN_READY = 1'b1;
        endcase
    end

    assign accept = IN_VALID & IN_READY & tgt_ok;
    assign drop   = IN_VALID & ~tgt_ok;
    assign load   = {4{accept}} & tgt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PTR <= PTR_RESET;
            ERR <= 1'b0;
        end else begin
            if (accept && (route_mode == ROUTE_PTR)) begin
                PTR <= {PTR[2:0], PTR[3]};
            end
            if (drop) begin
                ERR <= 1'b1;
            end else if (ERR_CLR) begin
                ERR <= 1'b0;
            end
        end
    end

    demux_chan_reg #(.WIDTH(INPUT_WIDTH)) u_ch1 (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (load[0]),
        .data_in   (IN),
        .out_ready (OUT_READY[0]),
        .data_out  (OUT1),
        .valid     (OUT_VALID[0])
    );

    demux_chan_reg #(.WIDTH(INPUT_WIDTH)) u_ch2 (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (load[1]),
        .data_in   (IN),
        .out_ready (OUT_READY[1]),
        .data_out  (OUT2),
        .valid     (OUT_VALID[1])
    );

    demux_chan_reg #(.WIDTH(INPUT_WIDTH)) u_ch3 (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (load[2]),
        .data_in   (IN),
        .out_ready (OUT_READY[2]),
        .data_out  (OUT3),
        .valid     (OUT_VALID[2])
    );

    demux_chan_reg #(.WIDTH(INPUT_WIDTH)) u_ch4 (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (load[3]),
        .data_in   (IN),
        .out_ready (OUT_READY[3]),
        .data_out  (OUT4),
        .valid     (OUT_VALID[3])
    );

endmodule
